// File: rtl/ov5640_capture_sequencer_if.sv
// Capture request/handshake and frame-event bundle between software/GPIO,
// the capture datapath and the capture sequencer.
interface ov5640_capture_sequencer_if;
    logic        axil_capture_req;
    logic        axil_capture_done;
    logic        gpio_capture_req;
    logic        gpio_capture_done;
    logic        frame_start;
    logic        frame_end;
    logic        capture_en;
    logic        capture_src;
    logic        capture_busy;
    logic        capture_timeout;
    logic [15:0] frame_cnt;

    modport master (
        output axil_capture_req, gpio_capture_req, frame_start, frame_end,
        input  axil_capture_done, gpio_capture_done, capture_en, capture_src,
               capture_busy, capture_timeout, frame_cnt
    );

    modport slave (
        input  axil_capture_req, gpio_capture_req, frame_start, frame_end,
        output axil_capture_done, gpio_capture_done, capture_en, capture_src,
               capture_busy, capture_timeout, frame_cnt
    );
endinterface

// File: rtl/ov5640_capture_sequencer.sv
// Arbitrates AXI-lite and GPIO capture requests and sequences one camera
// frame capture per grant, with a timeout abort and a completed-frame count.
module ov5640_capture_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26,
    parameter logic [15:0] FRAME_CNT_INIT = '0
) (
    input logic                        sys_clk,
    input logic                        sys_rst,
    ov5640_capture_sequencer_if.slave  cap
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [1:0]       gpio_sync;
    logic             gpio_prev;
    logic             gpio_rise;

    logic             axil_pend;
    logic             gpio_pend;
    logic             src;
    logic             timeout_flag;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      frames;

    logic             axil_serving;
    logic             axil_done;
    logic             axil_event;
    logic             grant;
    logic             grant_src;
    logic             cnt_expired;
    logic             frame_inc;
    logic             timeout_hit;

    assign gpio_rise    = gpio_sync[1] & ~gpio_prev;
    assign axil_done    = (state == DONE) && !src;
    assign axil_serving = (state != IDLE) && !src;
    assign axil_event   = cap.axil_capture_req & ~axil_pend & ~axil_serving & ~axil_done;
    assign grant        = (state == IDLE) && (axil_pend || gpio_pend);
    assign grant_src    = ~axil_pend;
    assign cnt_expired  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timeout beats a late frame_start in WAIT_SOF; a frame_end on the last
    // allowed CAPTURE cycle still counts as a completed frame.
    always_comb begin
        state_next  = state;
        frame_inc   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (cnt_expired) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end else if (cap.frame_start) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cap.frame_end) begin
                    state_next = DONE;
                    frame_inc  = 1'b1;
                end else if (cnt_expired) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                if (src || !cap.axil_capture_req) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gpio_sync    <= '0;
            gpio_prev    <= 1'b0;
            axil_pend    <= 1'b0;
            gpio_pend    <= 1'b0;
            src          <= 1'b0;
            timeout_flag <= 1'b0;
            cnt          <= '0;
            frames       <= FRAME_CNT_INIT;
        end else begin
            gpio_sync <= {gpio_sync[0], cap.gpio_capture_req};
            gpio_prev <= gpio_sync[1];

            if (grant && !grant_src) begin
                axil_pend <= 1'b0;
            end else if (axil_event) begin
                axil_pend <= 1'b1;
            end

            // A rising edge in the grant cycle is dropped: the flag is still set.
            if (grant && grant_src) begin
                gpio_pend <= 1'b0;
            end else if (gpio_rise) begin
                gpio_pend <= 1'b1;
            end

            if (grant) begin
                src          <= grant_src;
                cnt          <= '0;
                timeout_flag <= 1'b0;
            end else if (state == WAIT_SOF || state == CAPTURE) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (timeout_hit) timeout_flag <= 1'b1;
            if (frame_inc)   frames       <= frames + 16'd1;
        end
    end

    assign cap.axil_capture_done = axil_done;
    assign cap.gpio_capture_done = (state == DONE) && src;
    assign cap.capture_en        = (state == CAPTURE);
    assign cap.capture_busy      = (state != IDLE);
    assign cap.capture_src       = src;
    assign cap.capture_timeout   = timeout_flag;
    assign cap.frame_cnt         = frames;

endmodule
